vga_copper: RTL and testbench

VGA_COPPER -- requirements
Module: vga_copper

---
 rtl/vga_copper_pkg.sv | 30 +++
 rtl/vga_copper.sv | 108 ++++++++++
 tb/tb_vga_copper.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_copper_pkg.sv
// vga_copper_pkg: shared opcode/state enums, command-word field positions and register indices.
package vga_copper_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_JUMP  = 2'b01,
    OP_END   = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_BUS,
    S_GAP
  } state_e;

  localparam int CMD_W   = 40;
  localparam int OP_HI   = 39;
  localparam int OP_LO   = 38;
  localparam int IDX_HI  = 37;
  localparam int IDX_LO  = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [5:0] WAIT_COND   = 6'd6;
  localparam logic [5:0] BG_COLOR_01 = 6'd7;

endpackage

// File: rtl/vga_copper.sv
// vga_copper: command-list sequencer that fetches 40-bit words and replays WRITEs as Wishbone
// single writes, with JUMP/END flow control, level stop abort and a sticky reserved-opcode error.
module vga_copper
  import vga_copper_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] CORE_BASE = 8'h04
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_rd,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic [31:0]       wb_addr_o,
  output logic [31:0]       wb_data_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic              abort, abort_nx, done_nx, err_nx, load;
  opcode_e           op;

  assign op = opcode_e'(cmd_data[OP_HI:OP_LO]);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    abort_nx = abort;
    done_nx  = 1'b0;
    err_nx   = err;
    load     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_FETCH;
        pc_nx    = '0;
        abort_nx = 1'b0;
        err_nx   = 1'b0;
      end
      S_FETCH: begin
        state_nx = stop ? S_GAP : S_LATCH;
        abort_nx = stop;
      end
      S_LATCH: if (stop) begin
        state_nx = S_GAP;
        abort_nx = 1'b1;
      end else if (op == OP_WRITE) begin
        state_nx = S_BUS;
        load     = 1'b1;
      end else if (op == OP_JUMP) begin
        state_nx = S_FETCH;
        pc_nx    = cmd_data[ADDR_W-1:0];
      end else begin
        state_nx = S_IDLE;
        done_nx  = 1'b1;
        err_nx   = err | (op == OP_RSVD);
      end
      // an ack coinciding with stop still completes the write
      S_BUS: if (wb_ack_i || stop) begin
        state_nx = S_GAP;
        abort_nx = stop;
        pc_nx    = wb_ack_i ? pc + 1'b1 : pc;
      end
      S_GAP: state_nx = abort ? S_IDLE : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      abort     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      abort <= abort_nx;
      done  <= done_nx;
      err   <= err_nx;
      if (load) begin
        wb_addr_o <= {CORE_BASE, 16'h0, cmd_data[IDX_HI:IDX_LO], 2'b00};
        wb_data_o <= cmd_data[DATA_HI:DATA_LO];
      end
    end
  end

  assign cmd_rd   = state == S_FETCH;
  assign cmd_addr = pc;
  assign wb_cyc_o = state == S_BUS;
  assign wb_stb_o = state == S_BUS;
  assign wb_we_o  = state == S_BUS;
  assign wb_sel_o = {4{state == S_BUS}};
  assign busy     = state != S_IDLE;

endmodule

// File: tb/tb_vga_copper.sv
// tb_vga_copper: command memory and Wishbone slave models with a write scoreboard.
module tb_vga_copper;
  import vga_copper_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, stop, cmd_rd, wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, busy, done, err;
  logic [7:0]  cmd_addr;
  logic [39:0] cmd_data;
  logic [31:0] wb_addr_o, wb_data_o;
  logic [3:0]  wb_sel_o;
  logic [39:0] mem [256];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, writes = 0;
  int ack_delay = 0, ack_hold = 0, ack_limit = 1000000;
  int wait_cnt = 0, hold = 0, low_run = 0, last_low = 0, stb_len = 0, unstable = 0;
  logic [31:0] first_a, first_d;

  always #5 clk = ~clk;

  vga_copper dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cmd_addr(cmd_addr), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .done(done), .err(err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    cmd_data = '0;
    forever begin
      @(negedge clk);
      if (cmd_rd === 1'b1) cmd_data = mem[cmd_addr];
    end
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Slave: acks after ack_delay stalled cycles, optionally lingers ack for ack_hold cycles after stb drops.
  initial begin
    wb_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_stb_o === 1'b1 && wb_cyc_o === 1'b1) begin
        if (wait_cnt == 0) begin
          first_a  = wb_addr_o;
          first_d  = wb_data_o;
          last_low = low_run;
        end else if (wb_addr_o !== first_a || wb_data_o !== first_d) unstable++;
        low_run = 0;
        if (wait_cnt >= ack_delay && writes < ack_limit) begin
          wb_ack_i = 1'b1;
          stb_len  = wait_cnt + 1;
          hold     = ack_hold;
          writes++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL wb_write unexpected: got addr=%h data=%h, want no write", wb_addr_o, wb_data_o);
          end else begin
            got = sb.pop_front();
            if (wb_addr_o !== got.a || wb_data_o !== got.d || wb_sel_o !== 4'hF || wb_we_o !== 1'b1) begin
              errors++;
              $display("FAIL wb_write: got addr=%h data=%h sel=%h we=%b, want addr=%h data=%h sel=f we=1",
                       wb_addr_o, wb_data_o, wb_sel_o, wb_we_o, got.a, got.d);
            end
          end
        end else wb_ack_i = 1'b0;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        low_run++;
        wb_ack_i = hold > 0;
        if (hold > 0) hold--;
      end
    end
  end

  function automatic logic [39:0] mk(logic [1:0] op, logic [5:0] idx, logic [31:0] d);
    return {op, idx, d};
  endfunction

  task automatic expect_wr(logic [5:0] idx, logic [31:0] d);
    exp_t e;
    e.a = {8'h04, 16'h0, idx, 2'b00};
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(output int n);
    int base = done_cnt;
    for (int i = 0; i < 5000 && done_cnt == base; i++) @(negedge clk);
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done pulse, want one");
      n = -1;
    end else n = done_cyc - start_cyc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_stb_o, wb_cyc_o, wb_we_o, cmd_rd, done, err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {wb_stb_o, wb_cyc_o, wb_we_o, cmd_rd, done, err, busy});
    end
    checks++;
    if ({wb_addr_o, wb_data_o, wb_sel_o, cmd_addr} !== 76'b0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h data=%h sel=%h pc=%h, want all 0", wb_addr_o, wb_data_o, wb_sel_o, cmd_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int n, w0;
    mem[0] = mk(OP_WRITE, 6'd0, 32'h0A1B2C3D);
    mem[1] = mk(OP_END, 6'd0, 32'h0);
    expect_wr(6'd0, 32'h0A1B2C3D);
    w0 = writes;
    pulse_start();
    wait_done(n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL basic_latency: got %0d, want 6", n); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, want 0", busy); end
    checks++;
    if (writes - w0 !== 1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL basic_writes: got %0d (pending %0d), want 1 (pending 0)", writes - w0, sb.size());
    end
  endtask

  task automatic test_wait_cond();
    int n;
    ack_delay = 499;
    unstable  = 0;
    mem[0] = mk(OP_WRITE, WAIT_COND, 32'h00000155);
    mem[1] = mk(OP_WRITE, BG_COLOR_01, 32'h00123456);
    mem[2] = mk(OP_END, 6'd0, 32'h0);
    expect_wr(WAIT_COND, 32'h00000155);
    expect_wr(BG_COLOR_01, 32'h00123456);
    pulse_start();
    wait_done(n);
    ack_delay = 0;
    checks++;
    if (stb_len !== 500) begin errors++; $display("FAIL wait_stb_len: got %0d, want 500", stb_len); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL wait_stable: got %0d changes, want 0", unstable); end
    checks++;
    if (last_low !== 3) begin errors++; $display("FAIL wait_gap: got %0d low cycles, want 3", last_low); end
    checks++;
    if (n !== 1008 || sb.size() !== 0) begin
      errors++;
      $display("FAIL wait_latency: got %0d (pending %0d), want 1008 (pending 0)", n, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int n, w0;
    ack_hold = 2;
    for (int i = 0; i < 3; i++) begin
      mem[i] = mk(OP_WRITE, 6'(i + 1), 32'hC0DE0000 + 32'(i));
      expect_wr(6'(i + 1), 32'hC0DE0000 + 32'(i));
    end
    mem[3] = mk(OP_END, 6'd0, 32'h0);
    w0 = writes;
    pulse_start();
    wait_done(n);
    ack_hold = 0;
    checks++;
    if (writes - w0 !== 3 || sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_writes: got %0d (pending %0d), want 3 (pending 0)", writes - w0, sb.size());
    end
    checks++;
    if (last_low !== 3) begin errors++; $display("FAIL b2b_gap: got %0d low cycles, want 3", last_low); end
    checks++;
    if (n !== 14) begin errors++; $display("FAIL b2b_latency: got %0d, want 14", n); end
  endtask

  task automatic test_stop();
    int w0, d0;
    bit hit = 0;
    mem[0] = mk(OP_WRITE, BG_COLOR_01, 32'h00ABCDEF);
    mem[1] = mk(OP_JUMP, 6'd0, 32'h0);
    expect_wr(BG_COLOR_01, 32'h00ABCDEF);
    expect_wr(BG_COLOR_01, 32'h00ABCDEF);
    w0 = writes;
    d0 = done_cnt;
    ack_limit = writes + 2;
    pulse_start();
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk) #1;
      hit = wb_stb_o === 1'b1 && writes - w0 == 2;
    end
    stop = 1'b1;
    checks++;
    if (!hit) begin errors++; $display("FAIL stop_third_bus: got no third BUS, want one"); end
    @(posedge clk) #1;
    checks++;
    if ({wb_stb_o, wb_cyc_o, busy} !== 3'b001) begin
      errors++;
      $display("FAIL stop_drop: got stb,cyc,busy=%b, want 001", {wb_stb_o, wb_cyc_o, busy});
    end
    @(posedge clk) #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy=%b, want 0", busy); end
    stop = 1'b0;
    ack_limit = 1000000;
    checks++;
    if (writes - w0 !== 2 || done_cnt !== d0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL stop_result: got writes=%0d dones=%0d pending=%0d, want 2 0 0", writes - w0, done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_reserved();
    int n;
    mem[0] = mk(OP_WRITE, 6'd1, 32'h11111111);
    mem[1] = mk(OP_WRITE, 6'd2, 32'h22222222);
    mem[2] = mk(OP_RSVD, 6'd0, 32'h0);
    expect_wr(6'd1, 32'h11111111);
    expect_wr(6'd2, 32'h22222222);
    pulse_start();
    wait_done(n);
    checks++;
    if (n !== 10 || err !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_err: got latency=%0d err=%b, want 10 1", n, err);
    end
    mem[0] = mk(OP_END, 6'd0, 32'h0);
    pulse_start();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rsvd_clear: got err=%b, want 0", err); end
    wait_done(n);
    checks++;
    if (n !== 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_end: got latency=%0d err=%b, want 2 0", n, err);
    end
  endtask

  task automatic test_wrap();
    int n, w0;
    mem[0]   = mk(OP_JUMP, 6'd0, 32'd254);
    mem[254] = mk(OP_WRITE, 6'd3, 32'hAAAA0254);
    mem[255] = mk(OP_WRITE, 6'd4, 32'hBBBB0255);
    expect_wr(6'd3, 32'hAAAA0254);
    expect_wr(6'd4, 32'hBBBB0255);
    w0 = writes;
    pulse_start();
    for (int i = 0; i < 100 && writes - w0 < 1; i++) @(posedge clk) #1;
    mem[0] = mk(OP_END, 6'd0, 32'h0);
    wait_done(n);
    checks++;
    if (n !== 12 || writes - w0 !== 2 || sb.size() !== 0) begin
      errors++;
      $display("FAIL wrap: got latency=%0d writes=%0d pending=%0d, want 12 2 0", n, writes - w0, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit = 0;
    mem[0] = mk(OP_WRITE, 6'd5, 32'hDEADBEEF);
    ack_limit = writes;
    pulse_start();
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk) #1;
      hit = wb_stb_o === 1'b1;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!hit || {wb_stb_o, wb_cyc_o, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: got seen=%0d stb,cyc,busy=%b, want 1 000", hit, {wb_stb_o, wb_cyc_o, busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
    ack_limit = 1000000;
    mem[0] = mk(OP_WRITE, 6'd1, 32'h11112222);
    mem[1] = mk(OP_END, 6'd0, 32'h0);
    expect_wr(6'd1, 32'h11112222);
    pulse_start();
    checks++;
    if (cmd_rd !== 1'b1 || cmd_addr !== 8'd0) begin
      errors++;
      $display("FAIL restart_fetch: got rd=%b addr=%0d, want 1 0", cmd_rd, cmd_addr);
    end
    wait_done(n);
    checks++;
    if (n !== 6 || sb.size() !== 0) begin
      errors++;
      $display("FAIL restart_done: got latency=%0d pending=%0d, want 6 0", n, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mk(OP_END, 6'd0, 32'h0);
    test_reset();
    test_basic();
    test_wait_cond();
    test_back_to_back();
    test_stop();
    test_reserved();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
